// File: rtl/xbar_switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking, feeding the crossbar selects.
// Optional lock watchdog enabled by defining XBAR_ALLOC_LOCK_WATCHDOG_EN.
module xbar_switch_allocator #(
  parameter int unsigned IN_N         = 5,
  parameter int unsigned OUT_M        = 5,
  parameter int unsigned SEL_W        = $clog2(IN_N),
  parameter int unsigned DST_W        = $clog2(OUT_M),
  parameter int unsigned LOCK_TIMEOUT = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [IN_N-1:0]        req_valid_i,
  input  logic [IN_N*DST_W-1:0]  req_dst_i,
  input  logic [IN_N*2-1:0]      req_id_i,
  input  logic [OUT_M-1:0]       out_ready_i,
  output logic [IN_N-1:0]        grant_o,
  output logic [OUT_M*SEL_W-1:0] sel_o,
  output logic [OUT_M-1:0]       out_valid_o,
  output logic [OUT_M-1:0]       lock_err_o
);

  typedef enum logic {StIdle, StLocked} state_e;

  localparam logic [1:0] IdHead = 2'b10;
  localparam logic [1:0] IdTail = 2'b01;

  state_e           r_state [OUT_M];
  state_e           w_state_d [OUT_M];
  logic [SEL_W-1:0] r_owner [OUT_M];
  logic [SEL_W-1:0] w_owner_d [OUT_M];
  logic [SEL_W-1:0] r_ptr [OUT_M];
  logic [SEL_W-1:0] w_ptr_d [OUT_M];
  logic [SEL_W-1:0] r_sel [OUT_M];
  logic [SEL_W-1:0] w_sel_d [OUT_M];

  logic [IN_N-1:0]  w_elig [OUT_M];
  logic [SEL_W-1:0] w_win [OUT_M];
  logic [1:0]       w_win_id [OUT_M];
  logic [OUT_M-1:0] w_xfer;
  logic [IN_N-1:0]  w_grant;
  logic [OUT_M*SEL_W-1:0] w_sel_flat;

  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
    return (p == SEL_W'(IN_N - 1)) ? '0 : p + 1'b1;
  endfunction

  // Eligibility and winner search: upward from the pointer first, then the wrapped part.
  always_comb begin
    for (int j = 0; j < OUT_M; j++) begin
      w_xfer[j]   = 1'b0;
      w_win[j]    = r_sel[j];
      w_win_id[j] = 2'b00;
      w_elig[j]   = '0;
      for (int i = 0; i < IN_N; i++) begin
        if (req_valid_i[i] && (req_dst_i[i*DST_W +: DST_W] == DST_W'(j))) begin
          if (r_state[j] == StIdle) begin
            w_elig[j][i] = req_id_i[2*i+1];
          end else begin
            w_elig[j][i] = (SEL_W'(i) == r_owner[j]) && !req_id_i[2*i+1];
          end
        end
      end
      if (out_ready_i[j]) begin
        for (int i = 0; i < IN_N; i++) begin
          if (!w_xfer[j] && w_elig[j][i] && (SEL_W'(i) >= r_ptr[j])) begin
            w_xfer[j]   = 1'b1;
            w_win[j]    = SEL_W'(i);
            w_win_id[j] = req_id_i[2*i +: 2];
          end
        end
        for (int i = 0; i < IN_N; i++) begin
          if (!w_xfer[j] && w_elig[j][i] && (SEL_W'(i) < r_ptr[j])) begin
            w_xfer[j]   = 1'b1;
            w_win[j]    = SEL_W'(i);
            w_win_id[j] = req_id_i[2*i +: 2];
          end
        end
      end
    end
  end

  always_comb begin
    w_grant    = '0;
    w_sel_flat = '0;
    for (int j = 0; j < OUT_M; j++) begin
      w_sel_flat[j*SEL_W +: SEL_W] = w_win[j];
      for (int i = 0; i < IN_N; i++) begin
        if (w_xfer[j] && (w_win[j] == SEL_W'(i))) w_grant[i] = 1'b1;
      end
    end
  end

  assign grant_o     = rst_i ? '0 : w_grant;
  assign out_valid_o = rst_i ? '0 : w_xfer;
  assign sel_o       = rst_i ? '0 : w_sel_flat;

`ifdef XBAR_ALLOC_LOCK_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(LOCK_TIMEOUT + 1);

  logic [CntW-1:0]  r_cnt [OUT_M];
  logic [CntW-1:0]  w_cnt_d [OUT_M];
  logic [OUT_M-1:0] r_err;
  logic [OUT_M-1:0] w_err_d;

  assign lock_err_o = rst_i ? '0 : r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^LOCK_TIMEOUT;
  assign lock_err_o       = '0;
`endif

  always_comb begin
    for (int j = 0; j < OUT_M; j++) begin
      w_state_d[j] = r_state[j];
      w_owner_d[j] = r_owner[j];
      w_ptr_d[j]   = r_ptr[j];
      w_sel_d[j]   = r_sel[j];
      if (r_state[j] == StIdle) begin
        if (w_xfer[j]) begin
          w_ptr_d[j] = next_ptr(w_win[j]);
          w_sel_d[j] = w_win[j];
          if (w_win_id[j] == IdHead) begin
            w_state_d[j] = StLocked;
            w_owner_d[j] = w_win[j];
          end
        end
      end else if (w_xfer[j] && (w_win_id[j] == IdTail)) begin
        w_state_d[j] = StIdle;
      end
    end
`ifdef XBAR_ALLOC_LOCK_WATCHDOG_EN
    for (int j = 0; j < OUT_M; j++) begin
      w_cnt_d[j] = '0;
      w_err_d[j] = 1'b0;
      if ((r_state[j] == StLocked) && !w_xfer[j]) begin
        // Final stall cycle: release the lock and skip the stuck owner.
        if (r_cnt[j] == CntW'(LOCK_TIMEOUT - 1)) begin
          w_state_d[j] = StIdle;
          w_ptr_d[j]   = next_ptr(r_owner[j]);
          w_err_d[j]   = 1'b1;
        end else begin
          w_cnt_d[j] = r_cnt[j] + 1'b1;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int j = 0; j < OUT_M; j++) begin
        r_state[j] <= StIdle;
        r_owner[j] <= '0;
        r_ptr[j]   <= '0;
        r_sel[j]   <= '0;
`ifdef XBAR_ALLOC_LOCK_WATCHDOG_EN
        r_cnt[j]   <= '0;
`endif
      end
`ifdef XBAR_ALLOC_LOCK_WATCHDOG_EN
      r_err <= '0;
`endif
    end else begin
      for (int j = 0; j < OUT_M; j++) begin
        r_state[j] <= w_state_d[j];
        r_owner[j] <= w_owner_d[j];
        r_ptr[j]   <= w_ptr_d[j];
        r_sel[j]   <= w_sel_d[j];
`ifdef XBAR_ALLOC_LOCK_WATCHDOG_EN
        r_cnt[j]   <= w_cnt_d[j];
`endif
      end
`ifdef XBAR_ALLOC_LOCK_WATCHDOG_EN
      r_err <= w_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_xbar_switch_allocator.sv
// Directed self-checking bench for xbar_switch_allocator (5x5, lock timeout 4).
module tb_xbar_switch_allocator;

  localparam logic [1:0] HD = 2'b10, BD = 2'b00, TL = 2'b01, HT = 2'b11;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  req_valid_i;
  logic [14:0] req_dst_i;
  logic [9:0]  req_id_i;
  logic [4:0]  out_ready_i;
  logic [4:0]  grant_o;
  logic [14:0] sel_o;
  logic [4:0]  out_valid_o;
  logic [4:0]  lock_err_o;

  int nchk = 0;
  int nerr = 0;

  xbar_switch_allocator #(
    .IN_N(5), .OUT_M(5), .LOCK_TIMEOUT(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_dst_i(req_dst_i),
    .req_id_i(req_id_i), .out_ready_i(out_ready_i), .grant_o(grant_o), .sel_o(sel_o),
    .out_valid_o(out_valid_o), .lock_err_o(lock_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_req();
    req_valid_i = '0;
    req_dst_i   = '0;
    req_id_i    = '0;
  endtask

  task automatic set_req(input int i, input int d, input logic [1:0] id);
    req_valid_i[i]         = 1'b1;
    req_dst_i[i*3 +: 3]    = 3'(d);
    req_id_i[i*2 +: 2]     = id;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    out_ready_i = '1;
    clr_req();
    set_req(0, 0, HD);
    set_req(2, 3, HT);
    cyc();
    cyc();
    #1;
    nchk++; if (grant_o !== 5'b0) begin nerr++; $display("FAIL reset_grant got=%b exp=0", grant_o); end
    nchk++; if (out_valid_o !== 5'b0) begin nerr++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
    nchk++; if (sel_o !== 15'b0) begin nerr++; $display("FAIL reset_sel got=%h exp=0", sel_o); end
    nchk++; if (lock_err_o !== 5'b0) begin nerr++; $display("FAIL reset_err got=%b exp=0", lock_err_o); end
    rst_i = 1'b0;
    clr_req();
    cyc();
  endtask

  task automatic test_single_head();
    set_req(2, 3, HT);
    #1;
    nchk++; if (grant_o !== 5'b00100) begin nerr++; $display("FAIL single_grant got=%b exp=00100", grant_o); end
    nchk++; if (out_valid_o !== 5'b01000) begin nerr++; $display("FAIL single_valid got=%b exp=01000", out_valid_o); end
    nchk++; if (sel_o[9 +: 3] !== 3'd2) begin nerr++; $display("FAIL single_sel got=%0d exp=2", sel_o[9 +: 3]); end
    cyc();
    // Pointer is now 3, so input 3 beats input 2.
    set_req(3, 3, HT);
    #1;
    nchk++; if (grant_o !== 5'b01000) begin nerr++; $display("FAIL single_ptr got=%b exp=01000", grant_o); end
    nchk++; if (sel_o[9 +: 3] !== 3'd3) begin nerr++; $display("FAIL single_ptr_sel got=%0d exp=3", sel_o[9 +: 3]); end
    cyc();
    clr_req();
  endtask

  task automatic test_round_robin();
    int exp_w[4] = '{0, 1, 4, 0};
    set_req(0, 0, HT);
    set_req(1, 0, HT);
    set_req(4, 0, HT);
    for (int k = 0; k < 4; k++) begin
      #1;
      nchk++;
      if (grant_o !== 5'(1 << exp_w[k])) begin
        nerr++; $display("FAIL rr_grant[%0d] got=%b exp_input=%0d", k, grant_o, exp_w[k]);
      end
      nchk++;
      if (sel_o[0 +: 3] !== 3'(exp_w[k])) begin
        nerr++; $display("FAIL rr_sel[%0d] got=%0d exp=%0d", k, sel_o[0 +: 3], exp_w[k]);
      end
      cyc();
    end
    clr_req();
  endtask

  task automatic test_wormhole();
    logic [1:0] ids[4] = '{HD, BD, BD, TL};
    int g1 = 0;
    for (int k = 0; k < 4; k++) begin
      clr_req();
      set_req(1, 2, ids[k]);
      set_req(3, 2, HD);
      #1;
      if (grant_o[1]) g1++;
      nchk++; if (grant_o !== 5'b00010) begin nerr++; $display("FAIL worm_grant[%0d] got=%b exp=00010", k, grant_o); end
      cyc();
    end
    clr_req();
    set_req(3, 2, HD);
    #1;
    if (grant_o[1]) g1++;
    nchk++; if (g1 != 4) begin nerr++; $display("FAIL worm_count got=%0d exp=4", g1); end
    nchk++; if (grant_o !== 5'b01000) begin nerr++; $display("FAIL worm_next got=%b exp=01000", grant_o); end
    nchk++; if (sel_o[6 +: 3] !== 3'd3) begin nerr++; $display("FAIL worm_sel got=%0d exp=3", sel_o[6 +: 3]); end
    cyc();
    set_req(3, 2, TL);
    #1;
    nchk++; if (grant_o !== 5'b01000) begin nerr++; $display("FAIL worm_tail3 got=%b exp=01000", grant_o); end
    cyc();
    clr_req();
  endtask

  task automatic test_backpressure();
    // Output 2 pointer is 4: input 0 wins after the wrap.
    set_req(0, 2, HD);
    #1;
    nchk++; if (grant_o !== 5'b00001) begin nerr++; $display("FAIL bp_head got=%b exp=00001", grant_o); end
    cyc();
    set_req(0, 2, BD);
    set_req(4, 2, HD);
    out_ready_i[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      nchk++; if (grant_o !== 5'b0) begin nerr++; $display("FAIL bp_stall_grant[%0d] got=%b exp=0", k, grant_o); end
      nchk++; if (out_valid_o[2] !== 1'b0) begin nerr++; $display("FAIL bp_stall_valid[%0d] got=%b exp=0", k, out_valid_o[2]); end
      cyc();
    end
    out_ready_i[2] = 1'b1;
    #1;
    nchk++; if (grant_o !== 5'b00001) begin nerr++; $display("FAIL bp_resume got=%b exp=00001", grant_o); end
    nchk++; if (sel_o[6 +: 3] !== 3'd0) begin nerr++; $display("FAIL bp_sel got=%0d exp=0", sel_o[6 +: 3]); end
    cyc();
    clr_req();
    set_req(0, 2, HD);
    #1;
    nchk++; if (out_valid_o[2] !== 1'b0) begin nerr++; $display("FAIL bp_proto_err got=%b exp=0", out_valid_o[2]); end
    cyc();
    set_req(0, 2, TL);
    #1;
    nchk++; if (grant_o !== 5'b00001) begin nerr++; $display("FAIL bp_tail got=%b exp=00001", grant_o); end
    cyc();
    set_req(0, 2, HT);
    set_req(1, 2, HT);
    set_req(4, 2, HT);
    #1;
    nchk++; if (grant_o !== 5'b00010) begin nerr++; $display("FAIL bp_ptr got=%b exp=00010", grant_o); end
    cyc();
    clr_req();
  endtask

  task automatic test_reset_mid_packet();
    set_req(3, 1, HD);
    #1;
    nchk++; if (grant_o !== 5'b01000) begin nerr++; $display("FAIL rmp_head got=%b exp=01000", grant_o); end
    cyc();
    set_req(3, 1, BD);
    rst_i = 1'b1;
    #1;
    nchk++; if (grant_o !== 5'b0) begin nerr++; $display("FAIL rmp_rst_grant got=%b exp=0", grant_o); end
    cyc();
    rst_i = 1'b0;
    #1;
    nchk++; if (grant_o !== 5'b0) begin nerr++; $display("FAIL rmp_body got=%b exp=0", grant_o); end
    nchk++; if (out_valid_o[1] !== 1'b0) begin nerr++; $display("FAIL rmp_body_valid got=%b exp=0", out_valid_o[1]); end
    cyc();
    set_req(2, 1, HD);
    #1;
    nchk++; if (grant_o !== 5'b00100) begin nerr++; $display("FAIL rmp_new_head got=%b exp=00100", grant_o); end
    cyc();
    clr_req();
  endtask

  task automatic test_lock_hold();
    set_req(0, 4, HD);
    #1;
    nchk++; if (grant_o !== 5'b00001) begin nerr++; $display("FAIL wd_head got=%b exp=00001", grant_o); end
    cyc();
    clr_req();
    for (int k = 0; k < 4; k++) begin
      #1;
      nchk++; if (lock_err_o !== 5'b0) begin nerr++; $display("FAIL wd_stall_err[%0d] got=%b exp=0", k, lock_err_o); end
      cyc();
    end
    set_req(1, 4, HD);
    #1;
`ifdef XBAR_ALLOC_LOCK_WATCHDOG_EN
    nchk++; if (lock_err_o !== 5'b10000) begin nerr++; $display("FAIL wd_pulse got=%b exp=10000", lock_err_o); end
    nchk++; if (grant_o !== 5'b00010) begin nerr++; $display("FAIL wd_release got=%b exp=00010", grant_o); end
`else
    nchk++; if (lock_err_o !== 5'b0) begin nerr++; $display("FAIL wd_pulse got=%b exp=0", lock_err_o); end
    nchk++; if (grant_o !== 5'b0) begin nerr++; $display("FAIL wd_held got=%b exp=0", grant_o); end
`endif
    cyc();
    clr_req();
    #1;
    nchk++; if (lock_err_o !== 5'b0) begin nerr++; $display("FAIL wd_pulse_end got=%b exp=0", lock_err_o); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_head();
    test_round_robin();
    test_wormhole();
    test_backpressure();
    test_reset_mid_packet();
    test_lock_hold();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/xbar_switch_allocator.md
# xbar_switch_allocator

Per-output round-robin switch allocator with wormhole packet locking for the router switch. Sits directly upstream of the N×M parallel crossbar and produces its per-output select vector. Also produces per-input grants that pop input buffers, and per-output valid strobes for the output channels. Once a head flit wins an output, that output stays locked to its winner until the tail flit has passed.

## Interface
- `IN_N`, default 5: number of input channels.
- `OUT_M`, default 5: number of output channels.
- `SEL_W`, default `$clog2(IN_N)`: select width per output.
- `DST_W`, default `$clog2(OUT_M)`: requested-output index width per input.
- `LOCK_TIMEOUT`, default 64: watchdog limit in cycles (used only with the macro).
- Flit ID encoding (2 bits): `2'b10` HEAD, `2'b00` BODY, `2'b01` TAIL, `2'b11` HEAD_TAIL (single-flit packet).

Ports:
- `clk_i` input, 1: clock. Single clock domain.
- `rst_i` input, 1: reset. Synchronous, active-high.
- `req_valid_i` input, `IN_N`: input i holds a flit at its buffer head.
- `req_dst_i` input, `IN_N*DST_W`: output requested by input i, packed with i at LSB.
- `req_id_i` input, `IN_N*2`: flit ID of input i's head flit.
- `out_ready_i` input, `OUT_M`: output channel j can accept a flit this cycle.
- `grant_o` output, `IN_N`: input i's flit is transferred this cycle (buffer pop).
- `sel_o` output, `OUT_M*SEL_W`: crossbar select for output j.
- `out_valid_o` output, `OUT_M`: output j carries a valid flit this cycle.
- `lock_err_o` output, `OUT_M`: one-cycle pulse on a watchdog release.

## Operation
- Each output j has:
  - a lock FSM: `IDLE` or `LOCKED`;
  - an owner register (`SEL_W`);
  - a round-robin pointer (`SEL_W`).
- Input i requests output j when `req_valid_i[i]` is 1 and `req_dst_i[i]` equals j.
- **IDLE:**
  - Only requests carrying HEAD or HEAD_TAIL are eligible. BODY and TAIL requests are ignored; they receive no grant.
  - If `out_ready_i[j]` is 1, the winner is the first eligible input at or after the pointer, scanning upward modulo `IN_N`.
  - When a winner w exists, assert `grant_o[w]` and `out_valid_o[j]`, and drive `sel_o[j]` to w.
  - Next edge: the pointer becomes (w+1) mod `IN_N`. HEAD moves the FSM to `LOCKED` with owner w. HEAD_TAIL leaves the FSM in `IDLE`.
- **LOCKED:**
  - Only the owner is served. A transfer occurs when the owner requests j and `out_ready_i[j]` is 1.
  - On a transfer, assert the owner's grant and `out_valid_o[j]`.
  - A TAIL transfer returns the FSM to `IDLE` at the next edge.
  - A HEAD or HEAD_TAIL flit from the owner while locked is a protocol error. It is not granted.
- An input requests one output per cycle, so each input has at most one grant.
- `sel_o[j]` always drives the owner (LOCKED) or the current or last winner (IDLE). When `out_valid_o[j]` is 0, `sel_o[j]` holds its last value.
- Pointer arithmetic wraps: `IN_N-1` + 1 gives 0.

## Timing
- `grant_o`, `out_valid_o` and `sel_o` are combinational from the inputs and the registered state. Request to grant takes 0 cycles.
- FSM, owner and pointer update on the rising edge in the cycle of the grant.
- A tail transfer and a new head win on the same output cannot happen in the same cycle. The earliest new head win is the cycle after the tail transfer.
- When `out_ready_i[j]` is 0, there is no grant, no state change and no pointer movement.
- Reset, including mid-packet:
  - all FSMs `IDLE`, owners 0, pointers 0;
  - `sel_o` 0, `grant_o` 0, `out_valid_o` 0, `lock_err_o` 0;
  - any in-flight lock is dropped.
- While `rst_i` is high, all outputs are forced to 0 regardless of the request inputs.

## Configuration
- Macro: `XBAR_ALLOC_LOCK_WATCHDOG_EN`.
- **Defined:**
  - Each output has a stall counter. It counts cycles in `LOCKED` with no transfer and clears on any transfer.
  - When the count reaches `LOCK_TIMEOUT`, the FSM forces `IDLE` at the next edge and pulses `lock_err_o[j]` for one cycle.
  - The pointer moves to owner+1.
- **Undefined:** no counters are built, `lock_err_o` is tied to 0, and a lock is held indefinitely.

## Test plan
- **Reset and single head:** after reset, input 2 sends HEAD_TAIL to output 3 with ready=1.
  - Same cycle: `grant_o`=5'b00100, `out_valid_o[3]`=1, `sel_o[3]`=2.
  - After the edge: output 3 is `IDLE`, pointer=3.
- **Round-robin contention:** inputs 0, 1 and 4 send HEAD_TAIL to output 0 every cycle.
  - Grants rotate 0, 1, 4, 0.
  - After the winner at 4, the pointer wraps to 0.
- **Wormhole lock:** input 1 sends HEAD, BODY, BODY, TAIL to output 2 while input 3 continuously requests output 2 with HEAD.
  - Input 1 is granted 4 times.
  - Input 3 is first granted the cycle after the TAIL transfer.
- **Backpressure:** `out_ready_i[2]`=0 for 3 cycles mid-packet.
  - No grants, and `out_valid_o[2]`=0 during the stall.
  - Owner and pointer are unchanged. The transfer resumes when ready returns to 1.
- **Reset mid-packet and stray BODY:** assert `rst_i` after a HEAD has locked output 1, then present a BODY to output 1.
  - The BODY is not granted; output 1 is `IDLE`.
  - A new HEAD from another input is then granted.
- **Watchdog (macro defined, `LOCK_TIMEOUT`=4):** the owner stalls with no valid flit.
  - `lock_err_o[j]` pulses after 4 stall cycles and the output returns to `IDLE`.
  - With the macro undefined, the output stays `LOCKED`.
